sipo_deserializer: RTL
======================

// Module: sipo_deserializer
// PURPOSE
//   Serial-in parallel-out receiver; the far end of the 4-bit PISO link.
//   Collects WIDTH serial bits, qualified by a per-bit strobe, into a word.
//   Presents each word on a valid/ready output port through a holding register.
//   The next word can shift in while the current word waits for the consumer.
//   Flags words that are lost because the consumer stalled.
// PARAMETERS
//   WIDTH      4   bits per word; legal range 2..32
//   MSB_FIRST  1   1: first received bit -> dout[WIDTH-1] (matches PISO order); 0: first bit -> dout[0]
// PORTS
//   clk          in   1      clock; all logic is on the rising edge
//   rst          in   1      reset; synchronous, active-high
//   sin          in   1      serial data bit
//   sin_en       in   1      bit strobe; sin is sampled only when sin_en=1
//   sync         in   1      frame restart; discards any partial word
//   dout         out  WIDTH  assembled word (holding register)
//   dout_valid   out  1      dout holds an unconsumed word
//   dout_ready   in   1      consumer accepts; transfer when dout_valid & dout_ready
//   bit_cnt      out  $clog2(WIDTH+1)  bits collected in the current partial word
//   overrun      out  1      sticky; a completed word was dropped
//   overrun_clr  in   1      clears overrun
// BEHAVIOUR
//   Reset (rst=1 at posedge), all outputs go to 0:
//   - shift reg=0, bit_cnt=0, dout=0, dout_valid=0, overrun=0.
//   - rst overrides every other input, including mid-word and mid-hold; the partial word is lost.
//   Shift path, on a cycle with sin_en=1:
//   - MSB_FIRST=1: sreg <= {sreg[WIDTH-2:0], sin}.
//   - MSB_FIRST=0: sreg <= {sin, sreg[WIDTH-1:1]}.
//   - bit_cnt increments by 1.
//   - sin_en=0: sreg and bit_cnt hold. Gaps of any length between strobes are legal.
//   Word completion:
//   - The strobe with bit_cnt==WIDTH-1 completes a word. bit_cnt wraps to 0 on that cycle.
//   - The completed word (including that final bit) is offered to the holding register on the same edge.
//   - Latency: dout/dout_valid update on the edge that samples the last bit, so they are visible the next cycle.
//   Holding register, on a completion cycle:
//   - dout_valid=0: load dout, set dout_valid.
//   - dout_valid=1 and dout_ready=1: the old word is consumed and the new word loaded on the same edge.
//     dout_valid stays 1 and there is no overrun.
//   - dout_valid=1 and dout_ready=0: the new word is dropped. dout keeps the old word and overrun <= 1.
//   Holding register, on a non-completion cycle:
//   - dout_valid & dout_ready -> dout_valid <= 0. dout keeps its last value.
//   - dout is stable while dout_valid=1 and dout_ready=0.
//   sync:
//   - bit_cnt <= 0 and the partial word is discarded. The holding register is unaffected.
//   - sync & sin_en on the same cycle: the sampled bit is bit 0 of the new frame (bit_cnt <= 1).
//     The old partial word is never completed, even if bit_cnt was WIDTH-1.
//   overrun:
//   - Sticky until overrun_clr=1.
//   - Set and clear on the same cycle: set wins and overrun stays 1.
//   Throughput: one word per WIDTH strobes, with no dead cycles; strobes on consecutive cycles are legal.
// TESTING
//   1. WIDTH=4, MSB_FIRST=1, dout_ready=1. Strobe bits 1,0,1,1 on consecutive cycles
//      -> dout=4'hB, dout_valid=1 for exactly 1 cycle, starting the cycle after the 4th strobe; bit_cnt 0,1,2,3,0.
//   2. Loopback: PISO loads 4'h6 and shifts into this block
//      -> dout=4'h6. Repeat with MSB_FIRST=0 and strobes 0,1,1,0 -> dout=4'h6.
//   3. dout_ready=0; send 4'hA then 4'h5
//      -> dout stays 4'hA, overrun=1 after the 2nd word; overrun_clr pulse -> overrun=0.
//   4. Back-to-back words 4'h3, 4'hC. Consumer asserts ready exactly on the cycle the 2nd word completes
//      -> dout=4'hC, dout_valid stays 1, overrun=0.
//   5. After 2 bits, assert sync together with sin_en and sin=1, then bits 0,0,1
//      -> dout=4'h9; the discarded partial word never appears.
//   6. rst asserted after 3 bits while dout_valid=1
//      -> all outputs 0 the next cycle. The next 4 bits 0,1,1,1 -> dout=4'h7.

Source files
------------

// File: rtl/sipo_deserializer_if.sv
// Serial bit stream in, assembled words out on a valid/ready port, plus the frame, count and overrun side signals.
// The master modport drives the link and consumes words. The slave modport is the deserializer.
interface sipo_deserializer_if #(
    parameter int WIDTH = 4
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             sin;
    logic             sin_en;
    logic             sync;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic [CW-1:0]    bit_cnt;
    logic             overrun;
    logic             overrun_clr;

    modport master (
        output sin,
        output sin_en,
        output sync,
        output dout_ready,
        output overrun_clr,
        input  dout,
        input  dout_valid,
        input  bit_cnt,
        input  overrun
    );

    modport slave (
        input  sin,
        input  sin_en,
        input  sync,
        input  dout_ready,
        input  overrun_clr,
        output dout,
        output dout_valid,
        output bit_cnt,
        output overrun
    );
endinterface

// File: rtl/sipo_deserializer.sv
// Strobed serial-to-parallel receiver. A word appears in the holding register on the edge that samples its last bit.
// A word that completes while the held word is stalled (dout_ready=0) is dropped and sets sticky overrun. Shifting never stalls.
module sipo_deserializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    sipo_deserializer_if.slave bus
);
    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_sreg;
    logic [CW-1:0]    r_bit_cnt;
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;
    logic             r_overrun;

    logic [WIDTH-1:0] w_sreg_next;
    logic             w_complete;
    logic             w_load;
    logic             w_drop;
    logic             w_consume;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_sreg_next = {r_sreg[WIDTH-2:0], bus.sin};
        end else begin : g_lsb_first
            assign w_sreg_next = {bus.sin, r_sreg[WIDTH-1:1]};
        end
    endgenerate

    // sync restarts the frame, so a final strobe that arrives alongside it never completes the old word.
    assign w_complete = bus.sin_en & ~bus.sync & (r_bit_cnt == LAST);
    assign w_consume  = r_dout_valid & bus.dout_ready;
    assign w_load     = w_complete & (~r_dout_valid | bus.dout_ready);
    assign w_drop     = w_complete & r_dout_valid & ~bus.dout_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sreg       <= '0;
            r_bit_cnt    <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (bus.sin_en) begin
                r_sreg <= w_sreg_next;
            end

            if (bus.sync) begin
                r_bit_cnt <= bus.sin_en ? CW'(1) : '0;
            end else if (bus.sin_en) begin
                r_bit_cnt <= w_complete ? '0 : r_bit_cnt + CW'(1);
            end

            // Load and consume can coincide: the old word leaves as the new one lands.
            if (w_load) begin
                r_dout       <= w_sreg_next;
                r_dout_valid <= 1'b1;
            end else if (w_consume) begin
                r_dout_valid <= 1'b0;
            end

            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (bus.overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.bit_cnt    = r_bit_cnt;
    assign bus.overrun    = r_overrun;
endmodule
